// File: rtl/multisim_apb_pkg.sv
// Shared definitions for the multisim APB client push endpoint and its server-side peer.
package multisim_apb_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_PUSH = 4'b0010,
    ST_WAIT = 4'b0100,
    ST_DONE = 4'b1000
  } apb_client_state_t;

  localparam string APB_REQ_SUFFIX  = "_apb_req";
  localparam string APB_RESP_SUFFIX = "_apb_resp";

endpackage

// File: rtl/multisim_client_pull.sv
// Response-side channel endpoint: delivers one word per vld/rdy handshake from the link.
module multisim_client_pull #(
  parameter type data_t = logic
) (
  output logic  data_vld_o,
  output data_t data_o,
  input  logic  data_rdy_i,
  input  logic  chan_vld_i,
  input  data_t chan_data_i,
  output logic  chan_rdy_o
);

  assign data_vld_o = chan_vld_i;
  assign data_o     = chan_data_i;
  assign chan_rdy_o = data_rdy_i;

endmodule

// File: rtl/multisim_client_push.sv
// Request-side channel endpoint: forwards one word per vld/rdy handshake onto the link.
module multisim_client_push #(
  parameter type data_t = logic
) (
  input  logic  data_vld_i,
  input  data_t data_i,
  output logic  data_rdy_o,
  output logic  chan_vld_o,
  output data_t chan_data_o,
  input  logic  chan_rdy_i
);

  assign chan_vld_o  = data_vld_i;
  assign chan_data_o = data_i;
  assign data_rdy_o  = chan_rdy_i;

endmodule

// File: rtl/multisim_client_apb_push.sv
// APB subordinate that forwards each transfer as a request word over the multisim link
// and completes it with the matching response word.
module multisim_client_apb_push
  import multisim_apb_pkg::*;
#(
  parameter type apb_req_t  = logic,
  parameter type apb_resp_t = logic
) (
  input  logic        clk,
  input  logic        rst_n,
  input  string       server_name,
  input  apb_req_t    i_apb_s_req,
  input  logic        i_apb_s_psel,
  input  logic        i_apb_s_penable,
  output apb_resp_t   o_apb_s_resp,
  output logic        o_apb_s_pready,
  output logic        o_busy,
  output logic [31:0] o_txn_count,
  output logic        o_protocol_err,
  output string       req_chan_o,
  output string       resp_chan_o,
  output logic        req_vld_o,
  output apb_req_t    req_data_o,
  input  logic        req_rdy_i,
  input  logic        resp_vld_i,
  input  apb_resp_t   resp_data_i,
  output logic        resp_rdy_o
);

  apb_client_state_t state_q, state_d;
  apb_req_t          req_q, req_d;
  apb_resp_t         resp_q, resp_d;
  apb_resp_t         pull_data;
  logic [31:0]       cnt_q, cnt_d;
  logic              pready_q, pready_d;
  logic              abort_q, abort_d;
  logic              perr_q, perr_d;
  logic              push_vld, push_rdy, pull_vld, pull_rdy;
  logic              psel_lost;

  always_comb begin
    req_chan_o  = {server_name, APB_REQ_SUFFIX};
    resp_chan_o = {server_name, APB_RESP_SUFFIX};
  end

  multisim_client_push #(.data_t(apb_req_t)) u_push (
    .data_vld_i  (push_vld),
    .data_i      (req_q),
    .data_rdy_o  (push_rdy),
    .chan_vld_o  (req_vld_o),
    .chan_data_o (req_data_o),
    .chan_rdy_i  (req_rdy_i)
  );

  multisim_client_pull #(.data_t(apb_resp_t)) u_pull (
    .data_vld_o  (pull_vld),
    .data_o      (pull_data),
    .data_rdy_i  (pull_rdy),
    .chan_vld_i  (resp_vld_i),
    .chan_data_i (resp_data_i),
    .chan_rdy_o  (resp_rdy_o)
  );

  // Channel strobes come from registered state only, never from the APB inputs.
  assign push_vld  = (state_q == ST_PUSH);
  assign pull_rdy  = (state_q == ST_WAIT);
  assign psel_lost = abort_q | ~i_apb_s_psel;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    resp_d  = resp_q;
    cnt_d   = cnt_q;
    abort_d = abort_q;
    perr_d  = perr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_apb_s_psel && !i_apb_s_penable) begin
          req_d   = i_apb_s_req;
          abort_d = 1'b0;
          state_d = ST_PUSH;
        end else if (i_apb_s_penable) begin
          perr_d = 1'b1;
        end
      end
      ST_PUSH: begin
        // An aborted request is still pushed; it cannot be withdrawn from the link.
        abort_d = psel_lost;
        if (!i_apb_s_psel) perr_d = 1'b1;
        if (push_rdy) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        abort_d = psel_lost;
        if (!i_apb_s_psel) perr_d = 1'b1;
        if (pull_vld) begin
          resp_d  = pull_data;
          state_d = psel_lost ? ST_IDLE : ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (i_apb_s_psel && i_apb_s_penable) cnt_d = cnt_q + 32'd1;
        else perr_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign pready_d = (state_d == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      req_q    <= '0;
      resp_q   <= '0;
      cnt_q    <= '0;
      pready_q <= 1'b0;
      abort_q  <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      resp_q   <= resp_d;
      cnt_q    <= cnt_d;
      pready_q <= pready_d;
      abort_q  <= abort_d;
      perr_q   <= perr_d;
    end
  end

  assign o_apb_s_resp   = resp_q;
  assign o_apb_s_pready = pready_q;
  assign o_busy         = (state_q != ST_IDLE);
  assign o_txn_count    = cnt_q;
  assign o_protocol_err = perr_q;

endmodule

// File: tb/tb_multisim_client_apb_push.sv
// Directed and randomized bench for multisim_client_apb_push; the TB plays both the APB manager and the link.
module tb_multisim_client_apb_push;

  typedef struct packed {
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
  } apb_req_t;

  typedef struct packed {
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  string       server_name = "srv0";
  apb_req_t    i_apb_s_req = '0;
  logic        i_apb_s_psel = 1'b0;
  logic        i_apb_s_penable = 1'b0;
  apb_resp_t   o_apb_s_resp;
  logic        o_apb_s_pready;
  logic        o_busy;
  logic [31:0] o_txn_count;
  logic        o_protocol_err;
  string       req_chan_o, resp_chan_o;
  logic        req_vld_o;
  apb_req_t    req_data_o;
  logic        req_rdy_i = 1'b0;
  logic        resp_vld_i = 1'b0;
  apb_resp_t   resp_data_i = '0;
  logic        resp_rdy_o;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] cnt_exp = '0;
  logic        err_exp = 1'b0;

  multisim_client_apb_push #(.apb_req_t(apb_req_t), .apb_resp_t(apb_resp_t)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .server_name     (server_name),
    .i_apb_s_req     (i_apb_s_req),
    .i_apb_s_psel    (i_apb_s_psel),
    .i_apb_s_penable (i_apb_s_penable),
    .o_apb_s_resp    (o_apb_s_resp),
    .o_apb_s_pready  (o_apb_s_pready),
    .o_busy          (o_busy),
    .o_txn_count     (o_txn_count),
    .o_protocol_err  (o_protocol_err),
    .req_chan_o      (req_chan_o),
    .resp_chan_o     (resp_chan_o),
    .req_vld_o       (req_vld_o),
    .req_data_o      (req_data_o),
    .req_rdy_i       (req_rdy_i),
    .resp_vld_i      (resp_vld_i),
    .resp_data_i     (resp_data_i),
    .resp_rdy_o      (resp_rdy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic apb_req_t rand_req();
    apb_req_t r;
    r.paddr  = $urandom;
    r.pwrite = 1'($urandom_range(0, 1));
    r.pwdata = $urandom;
    r.pstrb  = 4'($urandom_range(0, 15));
    r.pprot  = 3'($urandom_range(0, 7));
    return r;
  endfunction

  // One APB transfer starting at a negedge; ends at the negedge after completion.
  task automatic xfer(input apb_req_t rq, input apb_resp_t rs, input int pstall,
                      input int rstall, input bit drop);
    apb_req_t got;
    int       n;
    bit       hs;
    i_apb_s_psel    = 1'b1;
    i_apb_s_penable = 1'b0;
    i_apb_s_req     = rq;
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_setup", 128'(o_busy), 128'd1);
    i_apb_s_penable = 1'b1;
    i_apb_s_req     = rand_req();
    n = 0; hs = 1'b0; got = '0;
    while (!hs && n < 200) begin
      req_rdy_i = (n >= pstall);
      hs  = req_vld_o && req_rdy_i;
      got = req_data_o;
      chk("pready_low_push", 128'(o_apb_s_pready), 128'd0);
      @(posedge clk); n++;
      @(negedge clk);
    end
    req_rdy_i = 1'b0;
    chk("push_word", 128'(got), 128'(rq));
    chk("push_edges", 128'(n), 128'(pstall + 1));
    if (drop) begin
      i_apb_s_psel    = 1'b0;
      i_apb_s_penable = 1'b0;
      err_exp = 1'b1;
    end
    n = 0; hs = 1'b0;
    resp_data_i = rs;
    while (!hs && n < 200) begin
      resp_vld_i = (n >= rstall);
      hs = resp_rdy_o && resp_vld_i;
      chk("pready_low_wait", 128'(o_apb_s_pready), 128'd0);
      @(posedge clk); n++;
      @(negedge clk);
    end
    resp_vld_i  = 1'b0;
    resp_data_i = '0;
    chk("resp_edges", 128'(n), 128'(rstall + 1));
    if (drop) begin
      chk("drop_pready", 128'(o_apb_s_pready), 128'd0);
      chk("drop_busy", 128'(o_busy), 128'd0);
    end else begin
      chk("pready_high", 128'(o_apb_s_pready), 128'd1);
      chk("resp_data", 128'(o_apb_s_resp), 128'(rs));
      @(posedge clk);
      @(negedge clk);
      cnt_exp = cnt_exp + 32'd1;
      i_apb_s_psel    = 1'b0;
      i_apb_s_penable = 1'b0;
      chk("pready_one_cycle", 128'(o_apb_s_pready), 128'd0);
      chk("busy_after_done", 128'(o_busy), 128'd0);
      chk("resp_held", 128'(o_apb_s_resp), 128'(rs));
    end
    chk("txn_count", 128'(o_txn_count), 128'(cnt_exp));
    chk("protocol_err", 128'(o_protocol_err), 128'(err_exp));
  endtask

  initial begin
    apb_req_t  rq;
    apb_resp_t rs;

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    chk("rst_pready", 128'(o_apb_s_pready), 128'd0);
    chk("rst_resp", 128'(o_apb_s_resp), 128'd0);
    chk("rst_busy", 128'(o_busy), 128'd0);
    chk("rst_count", 128'(o_txn_count), 128'd0);
    chk("rst_err", 128'(o_protocol_err), 128'd0);
    chk("rst_req_vld", 128'(req_vld_o), 128'd0);
    chk("rst_req_data", 128'(req_data_o), 128'd0);
    chk("rst_resp_rdy", 128'(resp_rdy_o), 128'd0);
    checks++;
    assert (req_chan_o == "srv0_apb_req") else begin
      failures++; $error("FAIL req_chan observed=%s expected=srv0_apb_req", req_chan_o);
    end
    checks++;
    assert (resp_chan_o == "srv0_apb_resp") else begin
      failures++; $error("FAIL resp_chan observed=%s expected=srv0_apb_resp", resp_chan_o);
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write, zero stall
    rq = '{paddr: 32'h10, pwrite: 1'b1, pwdata: 32'hDEADBEEF, pstrb: 4'hF, pprot: 3'd0};
    rs = '{prdata: 32'h0, pslverr: 1'b0};
    xfer(rq, rs, 0, 0, 1'b0);

    // Read with 5-cycle response stall
    rq = rand_req(); rq.pwrite = 1'b0;
    rs = '{prdata: 32'hCAFEF00D, pslverr: 1'b0};
    xfer(rq, rs, 0, 5, 1'b0);

    // Four back-to-back, pslverr on the third
    for (int i = 0; i < 4; i++) begin
      rq = rand_req();
      rs = '{prdata: $urandom, pslverr: (i == 2)};
      xfer(rq, rs, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
      chk("pslverr_field", 128'(o_apb_s_resp.pslverr), 128'(i == 2));
    end

    // PSEL dropped in WAIT, then a normal transfer
    xfer(rand_req(), '{prdata: $urandom, pslverr: 1'b0}, 1, 2, 1'b1);
    xfer(rand_req(), '{prdata: $urandom, pslverr: 1'b0}, 0, 0, 1'b0);

    // Reset asserted while in PUSH
    i_apb_s_psel = 1'b1; i_apb_s_penable = 1'b0; i_apb_s_req = rand_req();
    @(posedge clk);
    @(negedge clk);
    i_apb_s_penable = 1'b1;
    chk("push_busy", 128'(o_busy), 128'd1);
    chk("push_vld", 128'(req_vld_o), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 128'(o_busy), 128'd0);
    chk("midrst_count", 128'(o_txn_count), 128'd0);
    chk("midrst_err", 128'(o_protocol_err), 128'd0);
    chk("midrst_pready", 128'(o_apb_s_pready), 128'd0);
    chk("midrst_resp", 128'(o_apb_s_resp), 128'd0);
    chk("midrst_req_vld", 128'(req_vld_o), 128'd0);
    chk("midrst_req_data", 128'(req_data_o), 128'd0);
    @(negedge clk);
    rst_n = 1'b1; i_apb_s_psel = 1'b0; i_apb_s_penable = 1'b0;
    cnt_exp = '0; err_exp = 1'b0;
    @(negedge clk);

    // PENABLE without a setup phase
    i_apb_s_penable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_apb_s_penable = 1'b0;
    err_exp = 1'b1;
    chk("penable_only_err", 128'(o_protocol_err), 128'd1);
    chk("penable_only_busy", 128'(o_busy), 128'd0);

    // Counter wrap
    force dut.cnt_q = 32'hFFFF_FFFF;
    @(posedge clk);
    @(negedge clk);
    release dut.cnt_q;
    cnt_exp = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("count_preload", 128'(o_txn_count), 128'(cnt_exp));
    xfer(rand_req(), '{prdata: $urandom, pslverr: 1'b0}, 0, 0, 1'b0);
    chk("count_wrapped", 128'(o_txn_count), 128'd0);

    // Randomized transfers
    for (int i = 0; i < 6; i++) begin
      xfer(rand_req(), '{prdata: $urandom, pslverr: 1'($urandom_range(0, 1))},
           int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
